spr_search_sched: RTL

//  Time-multiplexes one shared search_idx_10bit instance across the R/G/B channels of a de-gamma'd pixel.

---
 rtl/spr_search_sched_pkg.sv | 27 ++
 rtl/spr_search_sched.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/spr_search_sched_pkg.sv
// Shared types and widths for the SPR search scheduler.
// One search unit is time-shared across R/G/B.
package spr_search_sched_pkg;

  localparam int PIX_W  = 10;
  localparam int IDX_W  = 5;
  localparam int LOW_W  = 8;
  localparam int HIGH_W = 9;
  localparam int LINE_W = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISS_R = 3'd1,
    ST_ISS_G = 3'd2,
    ST_ISS_B = 3'd3,
    ST_DRAIN = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  function automatic logic [PIX_W-1:0] chan(
    input logic [3*PIX_W-1:0] rgb,
    input int unsigned        c
  );
    return rgb[c*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/spr_search_sched.sv
// Sequences one shared search unit over R, G, B of a pixel
// and packs the three results for the SPR interpolator.
module spr_search_sched
  import spr_search_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_hs,
  input  logic                  i_vs,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3*PIX_W-1:0]    in_rgb,
  output logic                  srch_en,
  output logic [PIX_W-1:0]      srch_pix,
  output logic                  srch_hs,
  output logic                  srch_vs,
  input  logic [IDX_W-1:0]      srch_idx,
  input  logic [LOW_W-1:0]      srch_low,
  input  logic [HIGH_W-1:0]     srch_high,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3*IDX_W-1:0]    out_idx,
  output logic [3*LOW_W-1:0]    out_low,
  output logic [3*HIGH_W-1:0]   out_high,
  output logic [3*PIX_W-1:0]    out_pix,
  output logic [LINE_W-1:0]     out_x,
  output logic                  abort
);

  state_e               state_q, state_d;
  logic [3*PIX_W-1:0]   pix_q, pix_d;
  logic [3*IDX_W-1:0]   idx_q, idx_d;
  logic [3*LOW_W-1:0]   low_q, low_d;
  logic [3*HIGH_W-1:0]  high_q, high_d;
  logic [LINE_W-1:0]    x_q, x_d;
  logic                 abort_q, abort_d;
  logic                 blank;
  logic                 ok;
  logic                 pop;

  assign blank = ~(i_hs & i_vs);
  assign ok    = ~blank & rst_n;
  assign pop   = (state_q == ST_HOLD) & out_ready;

  assign srch_hs   = i_hs;
  assign srch_vs   = i_vs;
  assign out_valid = (state_q == ST_HOLD);
  assign out_idx   = idx_q;
  assign out_low   = low_q;
  assign out_high  = high_q;
  assign out_pix   = pix_q;
  assign out_x     = x_q;
  assign abort     = abort_q;

  // Next state, channel mux to the search unit, result capture demux
  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    idx_d    = idx_q;
    low_d    = low_q;
    high_d   = high_q;
    in_ready = 1'b0;
    srch_en  = 1'b0;
    srch_pix = '0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = ok;
        if (in_valid & ok) begin
          pix_d   = in_rgb;
          state_d = ST_ISS_R;
        end
      end
      ST_ISS_R: begin
        srch_en  = ~blank;
        srch_pix = chan(pix_q, 0);
        state_d  = ST_ISS_G;
      end
      ST_ISS_G: begin
        srch_en  = ~blank;
        srch_pix = chan(pix_q, 1);
        idx_d[0*IDX_W +: IDX_W]    = srch_idx;
        low_d[0*LOW_W +: LOW_W]    = srch_low;
        high_d[0*HIGH_W +: HIGH_W] = srch_high;
        state_d  = ST_ISS_B;
      end
      ST_ISS_B: begin
        srch_en  = ~blank;
        srch_pix = chan(pix_q, 2);
        idx_d[1*IDX_W +: IDX_W]    = srch_idx;
        low_d[1*LOW_W +: LOW_W]    = srch_low;
        high_d[1*HIGH_W +: HIGH_W] = srch_high;
        state_d  = ST_DRAIN;
      end
      ST_DRAIN: begin
        idx_d[2*IDX_W +: IDX_W]    = srch_idx;
        low_d[2*LOW_W +: LOW_W]    = srch_low;
        high_d[2*HIGH_W +: HIGH_W] = srch_high;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        in_ready = out_ready & ok;
        if (pop) begin
          state_d = ST_IDLE;
          if (in_valid & ok) begin
            pix_d   = in_rgb;
            state_d = ST_ISS_R;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (blank) state_d = ST_IDLE;
  end

  // Abort flag and line position bookkeeping
  always_comb begin
    abort_d = blank & (state_q != ST_IDLE) & ~pop;
    x_d     = x_q;
    if (pop)        x_d = x_q + 1'b1;
    else if (!i_hs) x_d = '0;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      idx_q   <= '0;
      low_q   <= '0;
      high_q  <= '0;
      x_q     <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      idx_q   <= idx_d;
      low_q   <= low_d;
      high_q  <= high_d;
      x_q     <= x_d;
      abort_q <= abort_d;
    end
  end

endmodule
